pry2idx_scan: RTL and testbench

Sequential priority scanner: accepts a request vector over a valid/ready handshake and streams the binary index of every set bit, one index per cycle, in priority order, with a last-beat flag. It is the decode-side companion to the combinational priority-to-one-hot converter. Each cycle it uses the priority-to-one-hot converter to pick the next bit, then encodes that one-hot to binary and clears the bit. It sits between request-vector producers (interrupt pending registers, free-slot masks) and index-driven consumers.

---
 rtl/synthesis_primitives_pkg.sv | 12 +
 rtl/pry2idx_scan_oht2bin.sv | 27 ++
 rtl/pry2oht.sv | 53 +++++
 rtl/pry2idx_scan.sv | 103 ++++++++++
 tb/tb_pry2idx_scan.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synthesis_primitives_pkg.sv
// Shared constants and helpers for the priority/index primitives.
// Holds scan direction names and the index-width function.
package synthesis_primitives_pkg;

  localparam string DIR_LSB = "LSB";
  localparam string DIR_MSB = "MSB";

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pry2idx_scan_oht2bin.sv
// One-hot to binary encoder built as an OR-tree of index masks.
// Each index bit ORs the one-hot lines whose position has that bit set.
module oht2bin
  import synthesis_primitives_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int SPLIT = 2,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] oht,
  output logic [IDX_W-1:0] idx
);

  if (SPLIT < 1 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("oht2bin: SPLIT must be a power of 2");
  end

  // OR each one-hot line into the index bits set in its position.
  always_comb begin
    idx = '0;
    for (int b = 0; b < IDX_W; b++)
      for (int i = 0; i < WIDTH; i++)
        if (((i >> b) & 1) == 1)
          idx[b] = idx[b] | oht[i];
  end

endmodule

// File: rtl/pry2oht.sv
// Priority to one-hot converter: keeps only the highest-priority set bit.
// DIRECTION picks LSB-first or MSB-first priority.
module pry2oht
  import synthesis_primitives_pkg::*;
#(
  parameter int    WIDTH          = 32,
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht
);

  localparam bit MSB_FIRST = (DIRECTION == DIR_MSB);

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] sel;

  if (SPLIT < 1 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("pry2oht: SPLIT must be a power of 2");
  end

  // Reorder so that bit 0 is always the highest priority.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < WIDTH; i++)
      fwd[i] = MSB_FIRST ? pry[WIDTH-1-i] : pry[i];
  end

  if (IMPLEMENTATION == 0) begin : g_arith
    assign sel = fwd & (~fwd + WIDTH'(1));
  end else begin : g_ripple
    // Ripple chain: a bit wins only if no lower bit is set.
    always_comb begin
      logic seen;
      seen = 1'b0;
      sel  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        sel[i] = fwd[i] & ~seen;
        seen   = seen | fwd[i];
      end
    end
  end

  // Restore the original bit order.
  always_comb begin
    oht = '0;
    for (int i = 0; i < WIDTH; i++)
      oht[i] = MSB_FIRST ? sel[WIDTH-1-i] : sel[i];
  end

endmodule

// File: rtl/pry2idx_scan.sv
// Sequential priority scanner: streams the index of every set bit.
// Optional PRY2IDX_SCAN_EMPTY_EN: zero vector yields one m_emp beat.
module pry2idx_scan
  import synthesis_primitives_pkg::*;
#(
  parameter  int    WIDTH          = 32,
  parameter  int    SPLIT          = 2,
  parameter  string DIRECTION      = "LSB",
  parameter  int    IMPLEMENTATION = 0,
  localparam int    IDX_W          = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_pry,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [IDX_W-1:0] m_idx,
`ifdef PRY2IDX_SCAN_EMPTY_EN
  output logic             m_emp,
`endif
  output logic             m_lst
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] oht;
  logic [WIDTH-1:0] rem_nxt;
  logic [IDX_W-1:0] nidx;
  logic             in_hs;
  logic             out_hs;

  assign s_rdy   = ~m_vld | (m_rdy & m_lst);
  assign in_hs   = s_vld & s_rdy;
  assign out_hs  = m_vld & m_rdy;
  assign src     = in_hs ? s_pry : rem;
  assign rem_nxt = src & ~oht;

  pry2oht #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_pry2oht (
    .pry (src),
    .oht (oht)
  );

  oht2bin #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_oht2bin (
    .oht (oht),
    .idx (nidx)
  );

  // Scan state: IDLE is !m_vld, SCAN is m_vld; m_lst marks the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      m_vld <= 1'b0;
      m_idx <= '0;
      m_lst <= 1'b0;
`ifdef PRY2IDX_SCAN_EMPTY_EN
      m_emp <= 1'b0;
`endif
    end else if (in_hs) begin
      if (s_pry != '0) begin
        m_vld <= 1'b1;
        m_idx <= nidx;
        rem   <= rem_nxt;
        m_lst <= (rem_nxt == '0);
`ifdef PRY2IDX_SCAN_EMPTY_EN
        m_emp <= 1'b0;
`endif
      end else begin
        rem <= '0;
`ifdef PRY2IDX_SCAN_EMPTY_EN
        m_vld <= 1'b1;
        m_idx <= '0;
        m_lst <= 1'b1;
        m_emp <= 1'b1;
`else
        m_vld <= 1'b0;
        m_lst <= 1'b0;
`endif
      end
    end else if (out_hs) begin
      if (!m_lst) begin
        m_idx <= nidx;
        rem   <= rem_nxt;
        m_lst <= (rem_nxt == '0);
`ifdef PRY2IDX_SCAN_EMPTY_EN
        m_emp <= 1'b0;
`endif
      end else begin
        m_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pry2idx_scan.sv
// Bench for pry2idx_scan: three lanes (32 LSB, 32 MSB, 5 LSB).
// Scoreboard queues filled on input handshake, drained by monitors.
module tb_pry2idx_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  s_vld, m_rdy, s_rdy, m_vld, m_lst, m_emp;
  logic [31:0] pry0, pry1;
  logic [4:0]  pry2;
  logic [4:0]  idx0, idx1;
  logic [2:0]  idx2;

  int checks = 0;
  int failures = 0;
  int q0[$], q1[$], q2[$];

  pry2idx_scan #(.WIDTH(32), .DIRECTION("LSB")) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld[0]), .s_rdy(s_rdy[0]),
    .s_pry(pry0), .m_vld(m_vld[0]), .m_rdy(m_rdy[0]), .m_idx(idx0),
`ifdef PRY2IDX_SCAN_EMPTY_EN
    .m_emp(m_emp[0]),
`endif
    .m_lst(m_lst[0]));

  pry2idx_scan #(.WIDTH(32), .DIRECTION("MSB")) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld[1]), .s_rdy(s_rdy[1]),
    .s_pry(pry1), .m_vld(m_vld[1]), .m_rdy(m_rdy[1]), .m_idx(idx1),
`ifdef PRY2IDX_SCAN_EMPTY_EN
    .m_emp(m_emp[1]),
`endif
    .m_lst(m_lst[1]));

  pry2idx_scan #(.WIDTH(5), .DIRECTION("LSB")) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld[2]), .s_rdy(s_rdy[2]),
    .s_pry(pry2), .m_vld(m_vld[2]), .m_rdy(m_rdy[2]), .m_idx(idx2),
`ifdef PRY2IDX_SCAN_EMPTY_EN
    .m_emp(m_emp[2]),
`endif
    .m_lst(m_lst[2]));

`ifndef PRY2IDX_SCAN_EMPTY_EN
  assign m_emp = '0;
`endif

  function automatic int wd(int l);
    return (l == 2) ? 5 : 32;
  endfunction

  function automatic int idx_of(int l);
    case (l)
      0: return int'(idx0);
      1: return int'(idx1);
      default: return int'(idx2);
    endcase
  endfunction

  function automatic void qpush(int l, int e);
    case (l)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int l);
    case (l)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qpop(int l);
    case (l)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference: list set bits in priority order; entry = idx<<2|emp<<1|lst.
  function automatic void model(int l, logic [31:0] v_in);
    logic [31:0] v;
    int n, seen, i;
    v = v_in;
    if (l == 2) v = v & 32'h1f;
    n = 0;
    seen = 0;
    for (int k = 0; k < wd(l); k++) n += int'(v[k]);
    if (n == 0) begin
`ifdef PRY2IDX_SCAN_EMPTY_EN
      qpush(l, 3);
`endif
      return;
    end
    for (int k = 0; k < wd(l); k++) begin
      i = (l == 1) ? (wd(l) - 1 - k) : k;
      if (v[i]) begin
        seen++;
        qpush(l, (i << 2) | ((seen == n) ? 1 : 0));
      end
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(int l, bit vld, logic [31:0] pry, bit rdy,
                       output bit hs);
    @(negedge clk);
    #1;
    s_vld[l] = vld;
    m_rdy[l] = rdy;
    case (l)
      0: pry0 = pry;
      1: pry1 = pry;
      default: pry2 = pry[4:0];
    endcase
    #1;
    hs = vld && s_rdy[l];
    if (hs) model(l, pry);
  endtask

  task automatic send(int l, logic [31:0] v);
    bit ok;
    bit hs;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      drive(l, 1'b1, v, 1'b1, hs);
      ok = hs;
    end
    chk($sformatf("send_timeout_l%0d", l), int'(ok), 1);
  endtask

  task automatic idle(int l, int n);
    bit hs;
    for (int t = 0; t < n; t++) drive(l, 1'b0, 32'h0, 1'b1, hs);
  endtask

  task automatic rand_lane(int l);
    bit hs;
    logic [31:0] v, one;
    int r;
    one = 32'h1;
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom % 8);
      case (r)
        0: v = 32'h0;
        1: v = one << ($urandom % wd(l));
        2: v = 32'hffff_ffff;
        3: v = $urandom & $urandom;
        default: v = $urandom;
      endcase
      drive(l, ($urandom % 3) != 0, v, ($urandom % 4) != 0, hs);
    end
    idle(l, 80);
    chk($sformatf("drain_l%0d", l), qsize(l), 0);
  endtask

  // Monitors: compare each accepted beat with the scoreboard head.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      int e;
      forever begin
        @(negedge clk);
        #3;
        if (rst_n && m_vld[g] && m_rdy[g]) begin
          if (qsize(g) == 0) begin
            chk($sformatf("unexpected_beat_l%0d", g), 1, 0);
          end else begin
            e = qpop(g);
            chk($sformatf("idx_l%0d", g), idx_of(g), e >> 2);
            chk($sformatf("lst_l%0d", g), int'(m_lst[g]), e & 1);
`ifdef PRY2IDX_SCAN_EMPTY_EN
            chk($sformatf("emp_l%0d", g), int'(m_emp[g]), (e >> 1) & 1);
`endif
            if ((e & 1) == 1)
              chk($sformatf("s_rdy_last_l%0d", g), int'(s_rdy[g]), 1);
          end
        end else if (rst_n && m_vld[g] && !m_rdy[g]) begin
          chk($sformatf("s_rdy_stall_l%0d", g), int'(s_rdy[g]), 0);
        end else if (rst_n && !m_vld[g]) begin
          chk($sformatf("s_rdy_idle_l%0d", g), int'(s_rdy[g]), 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    s_vld = '0;
    m_rdy = '0;
    pry0  = '0;
    pry1  = '0;
    pry2  = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_m_vld", int'(m_vld[0]), 0);
    chk("rst_m_idx", idx_of(0), 0);
    chk("rst_m_lst", int'(m_lst[0]), 0);
    chk("rst_s_rdy", int'(s_rdy[0]), 1);
    chk("rst_emp", int'(m_emp[0]), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    fork
      begin send(0, 32'h8000_0011); idle(0, 5); end
      begin send(1, 32'h8000_0011); idle(1, 5); end
      begin send(2, 32'h0000_0012); idle(2, 5); end
    join

    send(0, 32'h5);
    for (int t = 0; t < 3; t++) begin
      drive(0, 1'b1, 32'hffff, 1'b0, hs);
      chk("hold_vld", int'(m_vld[0]), 1);
      chk("hold_idx", idx_of(0), 0);
      chk("hold_lst", int'(m_lst[0]), 0);
      chk("hold_s_rdy", int'(s_rdy[0]), 0);
      chk("hold_no_accept", int'(hs), 0);
    end
    idle(0, 4);

    send(0, 32'h1);
    drive(0, 1'b1, 32'h2, 1'b1, hs);
    chk("b2b_accept", int'(hs), 1);
    chk("b2b_first_idx", idx_of(0), 0);
    drive(0, 1'b0, 32'h0, 1'b1, hs);
    chk("b2b_second_vld", int'(m_vld[0]), 1);
    chk("b2b_second_idx", idx_of(0), 1);
    idle(0, 3);

    send(0, 32'h0);
    drive(0, 1'b0, 32'h0, 1'b1, hs);
`ifdef PRY2IDX_SCAN_EMPTY_EN
    chk("zero_vld", int'(m_vld[0]), 1);
    chk("zero_idx", idx_of(0), 0);
    chk("zero_lst", int'(m_lst[0]), 1);
    chk("zero_emp", int'(m_emp[0]), 1);
`else
    chk("zero_vld", int'(m_vld[0]), 0);
    chk("zero_s_rdy", int'(s_rdy[0]), 1);
`endif
    idle(0, 3);

    send(0, 32'hf0);
    drive(0, 1'b0, 32'h0, 1'b1, hs);
    drive(0, 1'b0, 32'h0, 1'b0, hs);
    chk("mid_idx", idx_of(0), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(m_vld[0]), 0);
    chk("mid_rst_s_rdy", int'(s_rdy[0]), 1);
    while (q0.size() > 0) void'(q0.pop_front());
    #1;
    rst_n = 1'b1;
    idle(0, 6);
    chk("post_rst_vld", int'(m_vld[0]), 0);

    fork
      rand_lane(0);
      rand_lane(1);
      rand_lane(2);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
